ccip_interface_pipe: RTL and testbench

- Parametrised CCI-P boundary pipeline between the FIU-facing ports of `ccip_std_afu` and the user AFU.
- Inserts `RX_STAGES` register stages on Rx and `TX_STAGES` on Tx. Generalises the fixed single-stage interface register.
- The extra round-trip latency would break the CCI-P almost-full contract, so per-channel skid FIFOs on c0/c1 Tx absorb in-flight requests.
- The block regenerates the AFU-facing almost-full and flags overflow.

---
 rtl/ccip_if_pkg.sv | 88 ++++++++
 rtl/ccip_pipe_pkg.sv | 22 ++
 rtl/ccip_skid_fifo.sv | 70 +++++++
 rtl/ccip_interface_pipe.sv | 169 ++++++++++++++++
 tb/tb_ccip_interface_pipe.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ccip_if_pkg.sv
// Reduced CCI-P type set: the header, Rx and Tx structs this pipeline carries.
package ccip_if_pkg;

    typedef logic [511:0] t_ccip_clData;
    typedef logic [63:0]  t_ccip_mmioData;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_sel;
        logic        sop;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        hit_miss;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        hit_miss;
        logic        format;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        t_ccip_mmioData      data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

endpackage

// File: rtl/ccip_pipe_pkg.sv
// Shared constants and skid-FIFO entry types for the CCI-P boundary pipeline.
package ccip_pipe_pkg;
    import ccip_if_pkg::*;

    // Requests the FIU tolerates after it raises almFull.
    localparam int CCIP_TX_ALMFULL_SLACK = 8;

    typedef t_ccip_c0_ReqMemHdr t_skid_c0;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
    } t_skid_c1;

    // Fill level at which the AFU must be told to stop: leaves room for
    // everything already in flight through both pipes plus the AFU's slack.
    function automatic int almfull_thresh(input int depth, input int tx_stages,
                                          input int rx_stages);
        return depth - (tx_stages + rx_stages + CCIP_TX_ALMFULL_SLACK + 2);
    endfunction

endpackage

// File: rtl/ccip_skid_fifo.sv
// Skid FIFO absorbing in-flight Tx requests while the FIU holds almFull.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module ccip_skid_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    output T                       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   ovf
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          wr_en, rd_en;
    T              mem_q [DEPTH];

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer, occupancy and sticky-overflow next state.
    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (push && full && !rd_en);
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state clears asynchronously; queued entries are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/ccip_interface_pipe.sv
// Multi-stage CCI-P boundary register between the FIU and the user AFU.
// Tx c0/c1 land in skid FIFOs so the longer round trip cannot overrun the FIU;
// the AFU sees an almFull regenerated from FIFO occupancy.
module ccip_interface_pipe
    import ccip_if_pkg::*;
    import ccip_pipe_pkg::*;
#(
    parameter int RX_STAGES  = 2,
    parameter int TX_STAGES  = 2,
    parameter int SKID_DEPTH = 32
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset_n,
    input  t_if_ccip_Rx pck_cp2af_sRx,
    output t_if_ccip_Tx pck_af2cp_sTx,
    output logic        afu_softReset,
    output t_if_ccip_Rx afu_sRx,
    input  t_if_ccip_Tx afu_sTx,
    output logic [1:0]  ovf_err
);
    localparam int CNT_W      = $clog2(SKID_DEPTH) + 1;
    localparam int ALM_THRESH = almfull_thresh(SKID_DEPTH, TX_STAGES, RX_STAGES);
    localparam logic [CNT_W-1:0] ALM_THRESH_C = CNT_W'(ALM_THRESH);

    if (RX_STAGES < 1 || RX_STAGES > 8) begin : g_bad_rx
        $error("RX_STAGES must be in 1..8");
    end
    if (TX_STAGES < 1 || TX_STAGES > 8) begin : g_bad_tx
        $error("TX_STAGES must be in 1..8");
    end
    if ((SKID_DEPTH & (SKID_DEPTH - 1)) != 0) begin : g_bad_pow2
        $error("SKID_DEPTH must be a power of two");
    end
    if (SKID_DEPTH < RX_STAGES + TX_STAGES + CCIP_TX_ALMFULL_SLACK + 4) begin : g_bad_depth
        $error("SKID_DEPTH too small to cover the pipeline round trip");
    end

    // Rx pipe: payload unreset, valids / reset / almFull carried alongside with reset.
    t_if_ccip_Rx                   rx_data_q [RX_STAGES];
    t_if_ccip_Rx                   rx_data_d [RX_STAGES];
    logic [RX_STAGES-1:0][3:0]     rx_vld_q, rx_vld_d;
    logic [RX_STAGES-1:0]          rst_sync_q, rst_sync_d;
    logic [RX_STAGES-1:0][1:0]     alm_q, alm_d;

    t_if_ccip_Tx                   tx_pipe_q [TX_STAGES];
    t_if_ccip_Tx                   tx_pipe_d [TX_STAGES];
    t_if_ccip_Tx                   tx_last;
    t_if_ccip_c0_Tx                c0_out_q, c0_out_d;
    t_if_ccip_c1_Tx                c1_out_q, c1_out_d;
    t_if_ccip_c2_Tx                c2_out_q, c2_out_d;
    logic [1:0]                    fiu_alm_q, fiu_alm_d;

    t_skid_c0                      c0_wdata, c0_rdata;
    t_skid_c1                      c1_wdata, c1_rdata;
    logic [CNT_W-1:0]              c0_count, c1_count;
    logic                          c0_full, c1_full, c0_empty, c1_empty;
    logic                          c0_pop, c1_pop, c0_ovf, c1_ovf;

    assign tx_last  = tx_pipe_q[TX_STAGES-1];
    assign c0_wdata = tx_last.c0.hdr;
    assign c1_wdata = '{hdr: tx_last.c1.hdr, data: tx_last.c1.data};
    assign c0_pop   = !c0_empty && !fiu_alm_q[0];
    assign c1_pop   = !c1_empty && !fiu_alm_q[1];
    assign ovf_err  = {c1_ovf, c0_ovf};

    // Shift-register next state for both pipes and the output registers.
    always_comb begin
        rx_data_d[0]  = pck_cp2af_sRx;
        rx_vld_d[0]   = {pck_cp2af_sRx.c1.rspValid, pck_cp2af_sRx.c0.mmioWrValid,
                         pck_cp2af_sRx.c0.mmioRdValid, pck_cp2af_sRx.c0.rspValid};
        rst_sync_d[0] = 1'b0;
        alm_d[0]      = {(c1_count >= ALM_THRESH_C) || c1_full,
                         (c0_count >= ALM_THRESH_C) || c0_full};
        for (int i = 1; i < RX_STAGES; i++) begin
            rx_data_d[i]  = rx_data_q[i-1];
            rx_vld_d[i]   = rx_vld_q[i-1];
            rst_sync_d[i] = rst_sync_q[i-1];
            alm_d[i]      = alm_q[i-1];
        end
        tx_pipe_d[0] = afu_sTx;
        for (int i = 1; i < TX_STAGES; i++) begin
            tx_pipe_d[i] = tx_pipe_q[i-1];
        end
        fiu_alm_d      = {pck_cp2af_sRx.c1TxAlmFull, pck_cp2af_sRx.c0TxAlmFull};
        c0_out_d.hdr   = c0_rdata;
        c0_out_d.valid = c0_pop;
        c1_out_d.hdr   = c1_rdata.hdr;
        c1_out_d.data  = c1_rdata.data;
        c1_out_d.valid = c1_pop;
        c2_out_d       = tx_last.c2;
    end

    // Rx payload registers carry no reset.
    always_ff @(posedge pClk) begin
        rx_data_q <= rx_data_d;
    end

    // Rx valids clear; soft reset and regenerated almFull come up asserted.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            rx_vld_q   <= '0;
            rst_sync_q <= '1;
            alm_q      <= '1;
            fiu_alm_q  <= 2'b11;
        end else begin
            rx_vld_q   <= rx_vld_d;
            rst_sync_q <= rst_sync_d;
            alm_q      <= alm_d;
            fiu_alm_q  <= fiu_alm_d;
        end
    end

    // Tx pipe and FIU-facing output registers, cleared on reset.
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            for (int i = 0; i < TX_STAGES; i++) tx_pipe_q[i] <= '0;
            c0_out_q <= '0;
            c1_out_q <= '0;
            c2_out_q <= '0;
        end else begin
            tx_pipe_q <= tx_pipe_d;
            c0_out_q  <= c0_out_d;
            c1_out_q  <= c1_out_d;
            c2_out_q  <= c2_out_d;
        end
    end

    // Assemble the delayed Rx port with the regenerated almFull bits.
    always_comb begin
        afu_sRx                = rx_data_q[RX_STAGES-1];
        afu_sRx.c0.rspValid    = rx_vld_q[RX_STAGES-1][0];
        afu_sRx.c0.mmioRdValid = rx_vld_q[RX_STAGES-1][1];
        afu_sRx.c0.mmioWrValid = rx_vld_q[RX_STAGES-1][2];
        afu_sRx.c1.rspValid    = rx_vld_q[RX_STAGES-1][3];
        afu_sRx.c0TxAlmFull    = alm_q[RX_STAGES-1][0];
        afu_sRx.c1TxAlmFull    = alm_q[RX_STAGES-1][1];
        afu_softReset          = rst_sync_q[RX_STAGES-1];
        pck_af2cp_sTx.c0       = c0_out_q;
        pck_af2cp_sTx.c1       = c1_out_q;
        pck_af2cp_sTx.c2       = c2_out_q;
    end

    ccip_skid_fifo #(.T(t_skid_c0), .DEPTH(SKID_DEPTH)) u_skid_c0 (
        .clk   (pClk),
        .rst_n (pck_cp2af_softReset_n),
        .push  (tx_last.c0.valid),
        .wdata (c0_wdata),
        .pop   (c0_pop),
        .rdata (c0_rdata),
        .count (c0_count),
        .full  (c0_full),
        .empty (c0_empty),
        .ovf   (c0_ovf)
    );

    ccip_skid_fifo #(.T(t_skid_c1), .DEPTH(SKID_DEPTH)) u_skid_c1 (
        .clk   (pClk),
        .rst_n (pck_cp2af_softReset_n),
        .push  (tx_last.c1.valid),
        .wdata (c1_wdata),
        .pop   (c1_pop),
        .rdata (c1_rdata),
        .count (c1_count),
        .full  (c1_full),
        .empty (c1_empty),
        .ovf   (c1_ovf)
    );

endmodule

// File: tb/tb_ccip_interface_pipe.sv
// Directed bench for ccip_interface_pipe with RX_STAGES=2, TX_STAGES=2, SKID_DEPTH=32.
module tb_ccip_interface_pipe;
    import ccip_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    t_if_ccip_Rx s_rx;
    t_if_ccip_Tx s_tx;
    logic        afu_rst;
    t_if_ccip_Rx afu_rx;
    t_if_ccip_Tx afu_tx;
    logic [1:0]  ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int out1_q[$];
    int out1_cyc[$];
    int out0_q[$];

    always #5 clk = ~clk;

    ccip_interface_pipe #(.RX_STAGES(2), .TX_STAGES(2), .SKID_DEPTH(32)) dut (
        .pClk                  (clk),
        .pck_cp2af_softReset_n (rst_n),
        .pck_cp2af_sRx         (s_rx),
        .pck_af2cp_sTx         (s_tx),
        .afu_softReset         (afu_rst),
        .afu_sRx               (afu_rx),
        .afu_sTx               (afu_tx),
        .ovf_err               (ovf)
    );

    // Output monitor: record every FIU-side c0/c1 request with its cycle.
    always @(negedge clk) begin
        cyc++;
        if (s_tx.c1.valid) begin
            out1_q.push_back({s_tx.c1.data[15:0], s_tx.c1.hdr.mdata});
            out1_cyc.push_back(cyc);
        end
        if (s_tx.c0.valid) out0_q.push_back(int'(s_tx.c0.hdr.mdata));
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step(n);
        rst_n = 1'b1;
        step(4);
    endtask

    task automatic drive_c1(input int tag);
        afu_tx.c1.valid        = 1'b1;
        afu_tx.c1.hdr          = '0;
        afu_tx.c1.hdr.mdata    = 16'(tag);
        afu_tx.c1.hdr.address  = 42'(tag);
        afu_tx.c1.data         = '0;
        afu_tx.c1.data[15:0]   = ~16'(tag);
    endtask

    function automatic int exp_c1(input int tag);
        logic [15:0] t;
        t = 16'(tag);
        return {~t, t};
    endfunction

    task automatic check_order(input string nm, input int base, input int n);
        chk({nm, "_count"}, 64'(out1_q.size()), 64'(n));
        for (int i = 0; i < n && i < out1_q.size(); i++) begin
            chk({nm, "_data"}, 64'(out1_q[i]), 64'(exp_c1(base + i)));
            chk({nm, "_rate"}, 64'(out1_cyc[i] - out1_cyc[0]), 64'(i));
        end
    endtask

    typedef struct {
        logic        s0;
        logic        s2;
        logic        srx;
        logic [15:0] tag;
        int          lat0;
        int          lat2;
        int          latrx;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int sent;
        int first_alm;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h1234, 4, 3, 2};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 16'hBEEF, 4, 3, 2};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0F0F, 4, 3, 2};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h8001, 4, 3, 2};

        rst_n  = 1'b0;
        s_rx   = '0;
        afu_tx = '0;

        // Reset state and release timing.
        step(3);
        chk("rst_afu_softReset", 64'(afu_rst), 64'd1);
        chk("rst_almfull_c0", 64'(afu_rx.c0TxAlmFull), 64'd1);
        chk("rst_almfull_c1", 64'(afu_rx.c1TxAlmFull), 64'd1);
        chk("rst_tx_valids", 64'({s_tx.c0.valid, s_tx.c1.valid, s_tx.c2.mmioRdValid}), 64'd0);
        chk("rst_rx_valid", 64'(afu_rx.c0.rspValid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("rel1_afu_softReset", 64'(afu_rst), 64'd1);
        chk("rel1_almfull_c0", 64'(afu_rx.c0TxAlmFull), 64'd1);
        step(1);
        chk("rel2_afu_softReset", 64'(afu_rst), 64'd0);
        chk("rel2_almfull", 64'({afu_rx.c1TxAlmFull, afu_rx.c0TxAlmFull}), 64'd0);
        step(2);

        // Latency vectors for c0, c2 and Rx.
        foreach (vecs[v]) begin
            afu_tx.c0.valid          = vecs[v].s0;
            afu_tx.c0.hdr            = '0;
            afu_tx.c0.hdr.mdata      = vecs[v].tag;
            afu_tx.c0.hdr.address    = 42'(vecs[v].tag) << 6;
            afu_tx.c2.mmioRdValid    = vecs[v].s2;
            afu_tx.c2.hdr.tid        = vecs[v].tag[8:0];
            afu_tx.c2.data           = {4{vecs[v].tag}};
            s_rx.c0.rspValid         = vecs[v].srx;
            s_rx.c0.hdr.mdata        = vecs[v].tag;
            for (int k = 1; k <= 5; k++) begin
                step(1);
                if (k == 1) begin
                    afu_tx           = '0;
                    s_rx.c0.rspValid = 1'b0;
                end
                chk("lat_c0_valid", 64'(s_tx.c0.valid), 64'(vecs[v].s0 && k == vecs[v].lat0));
                if (vecs[v].s0 && k == vecs[v].lat0) begin
                    chk("lat_c0_mdata", 64'(s_tx.c0.hdr.mdata), 64'(vecs[v].tag));
                    chk("lat_c0_addr", 64'(s_tx.c0.hdr.address), 64'(vecs[v].tag) << 6);
                end
                chk("lat_c2_valid", 64'(s_tx.c2.mmioRdValid), 64'(vecs[v].s2 && k == vecs[v].lat2));
                if (vecs[v].s2 && k == vecs[v].lat2) begin
                    chk("lat_c2_tid", 64'(s_tx.c2.hdr.tid), 64'(vecs[v].tag[8:0]));
                    chk("lat_c2_data", s_tx.c2.data, {4{vecs[v].tag}});
                end
                chk("lat_rx_valid", 64'(afu_rx.c0.rspValid), 64'(vecs[v].srx && k == vecs[v].latrx));
                if (vecs[v].srx && k == vecs[v].latrx)
                    chk("lat_rx_mdata", 64'(afu_rx.c0.hdr.mdata), 64'(vecs[v].tag));
            end
        end

        // Backpressure: FIU blocks c1 for 40 cycles, AFU honours regenerated almFull.
        out1_q.delete();
        out1_cyc.delete();
        s_rx.c1TxAlmFull = 1'b1;
        sent      = 0;
        first_alm = -1;
        for (int k = 0; k < 40; k++) begin
            if (afu_rx.c1TxAlmFull) begin
                if (first_alm < 0) first_alm = k;
                afu_tx.c1.valid = 1'b0;
            end else begin
                drive_c1(16'h100 + sent);
                sent++;
            end
            step(1);
        end
        afu_tx.c1.valid  = 1'b0;
        s_rx.c1TxAlmFull = 1'b0;
        chk("bp_almfull_cycle", 64'(first_alm), 64'd22);
        chk("bp_sent", 64'(sent), 64'd22);
        chk("bp_count", 64'(dut.u_skid_c1.count_q), 64'd22);
        chk("bp_no_output_while_blocked", 64'(out1_q.size()), 64'd0);
        for (int w = 0; w < 100 && out1_q.size() < 22; w++) step(1);
        step(5);
        check_order("bp_drain", 16'h100, 22);
        chk("bp_almfull_after", 64'(afu_rx.c1TxAlmFull), 64'd0);
        chk("bp_ovf", 64'(ovf), 64'd0);

        // Overflow: 33 pushes into a blocked 32-entry FIFO.
        do_reset(2);
        out1_q.delete();
        out1_cyc.delete();
        s_rx.c1TxAlmFull = 1'b1;
        for (int k = 0; k < 33; k++) begin
            drive_c1(16'h200 + k);
            step(1);
        end
        afu_tx.c1.valid = 1'b0;
        step(6);
        chk("ovf_c1", 64'(ovf[1]), 64'd1);
        chk("ovf_c0", 64'(ovf[0]), 64'd0);
        chk("ovf_count", 64'(dut.u_skid_c1.count_q), 64'd32);
        s_rx.c1TxAlmFull = 1'b0;
        for (int w = 0; w < 100 && out1_q.size() < 32; w++) step(1);
        step(10);
        check_order("ovf_drain", 16'h200, 32);
        chk("ovf_sticky", 64'(ovf), 64'd2);

        // Mid-stream reset with 10 queued c1 entries and c0 streaming.
        do_reset(2);
        s_rx.c1TxAlmFull = 1'b1;
        for (int k = 0; k < 12; k++) begin
            afu_tx.c0.valid     = 1'b1;
            afu_tx.c0.hdr.mdata = 16'(16'h400 + k);
            if (k < 10) drive_c1(16'h300 + k);
            else afu_tx.c1.valid = 1'b0;
            step(1);
        end
        chk("mid_count_before", 64'(dut.u_skid_c1.count_q), 64'd10);
        chk("mid_c0_streaming", 64'(s_tx.c0.valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_c0_valid_drop", 64'(s_tx.c0.valid), 64'd0);
        chk("mid_c1_valid_drop", 64'(s_tx.c1.valid), 64'd0);
        chk("mid_count_zero", 64'(dut.u_skid_c1.count_q), 64'd0);
        chk("mid_afu_softReset", 64'(afu_rst), 64'd1);
        afu_tx = '0;
        out0_q.delete();
        out1_q.delete();
        out1_cyc.delete();
        step(1);
        rst_n = 1'b1;
        s_rx.c1TxAlmFull = 1'b0;
        step(30);
        chk("mid_no_c1_issue", 64'(out1_q.size()), 64'd0);
        chk("mid_no_c0_issue", 64'(out0_q.size()), 64'd0);
        drive_c1(16'h3AA);
        step(1);
        afu_tx.c1.valid = 1'b0;
        step(8);
        chk("mid_new_count", 64'(out1_q.size()), 64'd1);
        if (out1_q.size() > 0) chk("mid_new_data", 64'(out1_q[0]), 64'(exp_c1(16'h3AA)));

        // Full FIFO with push and pop landing in the same cycle.
        do_reset(2);
        out1_q.delete();
        out1_cyc.delete();
        s_rx.c1TxAlmFull = 1'b1;
        for (int k = 0; k < 32; k++) begin
            drive_c1(16'h500 + k);
            step(1);
        end
        afu_tx.c1.valid = 1'b0;
        step(4);
        chk("full_count_before", 64'(dut.u_skid_c1.count_q), 64'd32);
        drive_c1(16'h500 + 32);
        step(1);
        afu_tx.c1.valid  = 1'b0;
        s_rx.c1TxAlmFull = 1'b0;
        step(2);
        chk("full_count_pushpop", 64'(dut.u_skid_c1.count_q), 64'd32);
        chk("full_no_ovf", 64'(ovf), 64'd0);
        for (int w = 0; w < 100 && out1_q.size() < 33; w++) step(1);
        step(5);
        check_order("full_drain", 16'h500, 33);
        chk("full_ovf_end", 64'(ovf), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
